// File: rtl/ua_switch_sequencer.sv
// ua_switch_sequencer
// Time-shares the analog bus between pads ua[NUM_CH-1:0] by driving one-hot
// enables for the transmission gates. Each connection is break-before-make:
// BBM_CYCLES all-open cycles, a programmable settle period, then a dwell
// window whose first cycle carries a sample strobe.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   cfg_we/addr/wdata  register writes: 0=MASK 1=SETTLE 2=DWELL 3=CTRL(bit0 CONT)
//   start              begin a scan frame (honoured only when idle)
//   stop               graceful halt at the end of the current dwell
//   sw_en              one-hot (or zero) switch enables
//   channel            selected channel index
//   sample_strobe      first dwell cycle
//   frame_done         last dwell cycle of the last channel in the frame
//   busy               not idle
//
// state    | meaning
// ---------+---------------------------------------------
// S_IDLE   | all switches open, waiting for start
// S_BREAK  | all switches open for BBM_CYCLES cycles
// S_SETTLE | selected switch closed, settling (SETTLE cycles)
// S_DWELL  | selected switch closed, sampling window
module ua_switch_sequencer #(
  parameter int NUM_CH     = 6,
  parameter int BBM_CYCLES = 2,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [7:0]        cfg_wdata,
  input  logic              start,
  input  logic              stop,
  output logic [NUM_CH-1:0] sw_en,
  output logic [2:0]        channel,
  output logic              sample_strobe,
  output logic              frame_done,
  output logic              busy
);

  localparam int CH_W = 3;
  localparam logic [CNT_W-1:0] BBM_LOAD = CNT_W'(BBM_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_SETTLE, S_DWELL} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   channel_q, channel_d;
  logic              first_q, first_d;
  logic              stop_pending_q, stop_pending_d;
  logic [NUM_CH-1:0] mask_q;
  logic [CNT_W-1:0]  settle_q, dwell_q;
  logic              cont_q;

  logic              lowest_ok, above_ok, stop_eff;
  logic [CH_W-1:0]   lowest_ch, above_ch;
  logic [CNT_W-1:0]  dwell_load;

  // DWELL=0 behaves as a single-cycle dwell.
  assign dwell_load = (dwell_q == '0) ? '0 : dwell_q - 1'b1;

  // Channel selection: lowest set mask bit, and next set bit above channel_q.
  always_comb begin
    lowest_ok = 1'b0;
    lowest_ch = '0;
    above_ok  = 1'b0;
    above_ch  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        lowest_ok = 1'b1;
        lowest_ch = CH_W'(i);
        if (CH_W'(i) > channel_q) begin
          above_ok = 1'b1;
          above_ch = CH_W'(i);
        end
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    channel_d      = channel_q;
    first_d        = 1'b0;
    stop_eff       = stop_pending_q | stop;
    stop_pending_d = stop_eff;
    sw_en          = '0;
    sample_strobe  = 1'b0;
    frame_done     = 1'b0;
    busy           = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        stop_pending_d = 1'b0;
        if (start && lowest_ok) begin
          channel_d = lowest_ch;
          state_d   = S_BREAK;
          cnt_d     = BBM_LOAD;
        end
      end
      S_BREAK: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (settle_q != '0) begin
          state_d = S_SETTLE;
          cnt_d   = settle_q - 1'b1;
        end else begin
          state_d = S_DWELL;
          cnt_d   = dwell_load;
          first_d = 1'b1;
        end
      end
      S_SETTLE: begin
        sw_en = NUM_CH'(1) << channel_q;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_DWELL;
          cnt_d   = dwell_load;
          first_d = 1'b1;
        end
      end
      S_DWELL: begin
        sw_en         = NUM_CH'(1) << channel_q;
        sample_strobe = first_q;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (above_ok) begin
          // More channels in this frame; a pending stop still halts here.
          if (stop_eff) begin
            state_d = S_IDLE;
          end else begin
            channel_d = above_ch;
            state_d   = S_BREAK;
            cnt_d     = BBM_LOAD;
          end
        end else begin
          frame_done = 1'b1;
          if (cont_q && lowest_ok && !stop_eff) begin
            channel_d = lowest_ch;
            state_d   = S_BREAK;
            cnt_d     = BBM_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) stop_pending_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      channel_q      <= '0;
      first_q        <= 1'b0;
      stop_pending_q <= 1'b0;
      mask_q         <= '0;
      settle_q       <= '0;
      dwell_q        <= CNT_W'(1);
      cont_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      channel_q      <= channel_d;
      first_q        <= first_d;
      stop_pending_q <= stop_pending_d;
      if (cfg_we) begin
        case (cfg_addr)
          2'd0: mask_q   <= cfg_wdata[NUM_CH-1:0];
          2'd1: settle_q <= CNT_W'(cfg_wdata);
          2'd2: dwell_q  <= CNT_W'(cfg_wdata);
          2'd3: cont_q   <= cfg_wdata[0];
          default: ;
        endcase
      end
    end
  end

  assign channel = channel_q;

endmodule

// File: tb/tb_ua_switch_sequencer.sv
// Testbench for ua_switch_sequencer: directed scenarios with literal
// expectations, then randomized traffic checked against a connection-timeline
// model plus one-hot / break-before-make / strobe-count invariants.
module tb_ua_switch_sequencer;
  localparam int NCH = 6;
  localparam int B   = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_we = 1'b0;
  logic [1:0]     cfg_addr = '0;
  logic [7:0]     cfg_wdata = '0;
  logic           start = 1'b0;
  logic           stop = 1'b0;
  logic [NCH-1:0] sw_en;
  logic [2:0]     channel;
  logic           sample_strobe, frame_done, busy;

  ua_switch_sequencer #(.NUM_CH(NCH), .BBM_CYCLES(B), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .start(start), .stop(stop), .sw_en(sw_en),
    .channel(channel), .sample_strobe(sample_strobe),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a connection is a timeline t = 0,1,2,... starting at its first
  // BREAK cycle: [0,B) open, [B,B+S) settle, [B+S,B+S+D) dwell.
  int m_busy = 0, m_ch = 0, m_t = 0, m_S = 0, m_D = 1;
  int m_mask = 0, m_settle = 0, m_dwell = 1, m_cont = 0, m_stop = 0;
  int m_entries = 0;

  function automatic int lowest(input int mask);
    for (int i = 0; i < NCH; i++) if (mask[i]) return i;
    return -1;
  endfunction

  function automatic int above(input int mask, input int ch);
    for (int i = ch + 1; i < NCH; i++) if (mask[i]) return i;
    return -1;
  endfunction

  task automatic model_edge();
    int se, nx;
    if (rst) begin
      m_busy = 0; m_ch = 0; m_t = 0; m_mask = 0; m_settle = 0;
      m_dwell = 1; m_cont = 0; m_stop = 0;
      return;
    end
    if (m_busy == 0) begin
      if (start && m_mask != 0) begin
        m_busy = 1; m_ch = lowest(m_mask); m_t = 0;
      end
    end else begin
      se = (m_stop != 0 || stop) ? 1 : 0;
      if (m_t >= B + m_S && m_t == B + m_S + m_D - 1) begin
        nx = above(m_mask, m_ch);
        if (nx >= 0 && se == 0) begin
          m_ch = nx; m_t = 0;
        end else if (nx < 0 && m_cont != 0 && m_mask != 0 && se == 0) begin
          m_ch = lowest(m_mask); m_t = 0;
        end else begin
          m_busy = 0;
        end
      end else begin
        m_t++;
        if (m_t == B) m_S = m_settle;
        if (m_t >= B && m_t == B + m_S) begin
          m_D = (m_dwell < 1) ? 1 : m_dwell;
          m_entries++;
        end
      end
      m_stop = m_busy ? se : 0;
    end
    if (cfg_we) begin
      case (cfg_addr)
        2'd0: m_mask   = cfg_wdata % 64;
        2'd1: m_settle = cfg_wdata;
        2'd2: m_dwell  = cfg_wdata;
        default: m_cont = cfg_wdata % 2;
      endcase
    end
  endtask

  always @(posedge clk) model_edge();

  bit en = 0;
  int strobes = 0;
  int zrun = 0;
  logic [NCH-1:0] last_sw = '0;

  always @(negedge clk) begin
    int e_sw, e_st, e_fd;
    if (en) begin
      e_sw = 0; e_st = 0; e_fd = 0;
      if (m_busy != 0 && m_t >= B) begin
        e_sw = 1 << m_ch;
        if (m_t == B + m_S) e_st = 1;
        if (m_t >= B + m_S && m_t == B + m_S + m_D - 1 && above(m_mask, m_ch) < 0) e_fd = 1;
      end
      chk("m_sw_en", sw_en, e_sw);
      chk("m_channel", channel, m_ch);
      chk("m_strobe", sample_strobe, e_st);
      chk("m_frame_done", frame_done, e_fd);
      chk("m_busy", busy, m_busy);
      chk("onehot", ($countones(sw_en) <= 1) ? 1 : 0, 1);
      if (sample_strobe) strobes++;
      if (sw_en != 0) begin
        if (last_sw != 0 && sw_en != last_sw) chk("bbm_gap", (zrun >= B) ? 1 : 0, 1);
        last_sw = sw_en;
        zrun = 0;
      end else begin
        zrun++;
      end
    end
  end

  // Drives one register write; call at a negedge, returns at the next one.
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  initial begin
    int seen1, fdc;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    en = 1;
    chk("rst_sw_en", sw_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_channel", channel, 0);

    // Two-channel single frame.
    wr(0, 8'h05); wr(1, 2); wr(2, 3); wr(3, 0);
    pulse_start();
    for (int c = 1; c <= 15; c++) begin
      if (c == 2)  chk("t1_c2_sw", sw_en, 0);
      if (c == 3)  chk("t1_c3_sw", sw_en, 1);
      if (c == 5)  chk("t1_c5_strobe", sample_strobe, 1);
      if (c == 7)  chk("t1_c7_sw", sw_en, 1);
      if (c == 7)  chk("t1_c7_fd", frame_done, 0);
      if (c == 8)  chk("t1_c8_sw", sw_en, 0);
      if (c == 10) chk("t1_c10_sw", sw_en, 4);
      if (c == 10) chk("t1_c10_ch", channel, 2);
      if (c == 12) chk("t1_c12_strobe", sample_strobe, 1);
      if (c == 14) chk("t1_c14_fd", frame_done, 1);
      if (c == 15) chk("t1_c15_busy", busy, 0);
      @(negedge clk);
    end

    // Continuous single channel, zero settle and zero dwell.
    wr(1, 0); wr(2, 0); wr(0, 8'h20); wr(3, 1);
    pulse_start();
    for (int c = 1; c <= 9; c++) begin
      if (c % 3 == 0) begin
        chk("t2_sw_on", sw_en, 32);
        chk("t2_strobe", sample_strobe, 1);
        chk("t2_fd", frame_done, 1);
      end else begin
        chk("t2_sw_off", sw_en, 0);
      end
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_idle(20);

    // Stop during ch0 settle of a continuous scan.
    wr(0, 8'h03); wr(1, 2); wr(2, 2); wr(3, 1);
    pulse_start();
    seen1 = 0; fdc = 0;
    for (int c = 1; c <= 12; c++) begin
      stop = (c == 3);
      seen1 += sw_en[1];
      fdc += frame_done;
      if (c == 5) chk("t3_c5_strobe", sample_strobe, 1);
      if (c == 7) chk("t3_c7_busy", busy, 0);
      @(negedge clk);
    end
    chk("t3_ch1_never", seen1, 0);
    chk("t3_no_fd", fdc, 0);

    // Start with empty mask, then mask cleared mid-frame.
    wr(0, 0);
    start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("t4_nomask_busy", busy, 0);
    end
    start = 1'b0;
    wr(0, 8'h03); wr(1, 0); wr(2, 3); wr(3, 1);
    pulse_start();
    for (int c = 1; c <= 12; c++) begin
      cfg_we = (c == 8); cfg_addr = 0; cfg_wdata = 0;
      if (c == 8)  chk("t4_c8_sw", sw_en, 2);
      if (c == 10) chk("t4_c10_fd", frame_done, 1);
      if (c == 11) chk("t4_c11_busy", busy, 0);
      @(negedge clk);
    end
    cfg_we = 1'b0;

    // Reset during dwell.
    wr(0, 8'h01); wr(1, 0); wr(2, 5); wr(3, 0);
    pulse_start();
    for (int c = 1; c <= 9; c++) begin
      rst = (c == 4);
      start = (c == 6);
      if (c == 4) chk("t5_c4_sw", sw_en, 1);
      if (c == 5) chk("t5_c5_sw", sw_en, 0);
      if (c == 5) chk("t5_c5_busy", busy, 0);
      if (c >= 7) chk("t5_nomask_busy", busy, 0);
      @(negedge clk);
    end
    start = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 10000; n++) begin
      rst = ($urandom_range(0, 1999) == 0);
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_addr = 2'($urandom_range(0, 3));
      cfg_wdata = (cfg_addr == 1 || cfg_addr == 2) ? 8'($urandom_range(0, 4))
                                                    : 8'($urandom_range(0, 255));
      start = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 40) == 0);
      @(negedge clk);
    end
    rst = 1'b0; cfg_we = 1'b0; start = 1'b0; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_idle(100);
    chk("strobe_count", strobes, m_entries);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ua_switch_sequencer.md
Name: ua_switch_sequencer

Overview:
- Time-shares the analog bus between pads ua[5:0] by driving one-hot enables for the on-chip analog transmission gates.
- Each connection uses break-before-make: a programmable settle period, then a dwell window that carries a sample strobe for the downstream sampling logic.
- Sits in the digital domain of tt_um_mithro_test. It is configured from a small register interface that the top level drives from ui_in/uio_in.

Parameters:
- NUM_CH, 6, number of switchable analog channels (ua[NUM_CH-1:0]).
- BBM_CYCLES, 2, cycles all switches are open before any new channel closes (>=1).
- CNT_W, 8, width of the settle and dwell counters.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset. The top level drives it from ~rst_n.
- cfg_we  input  1  config write strobe, sampled on rising edge.
- cfg_addr  input  2  register select: 0=MASK[5:0], 1=SETTLE, 2=DWELL, 3=CTRL (bit0 CONT).
- cfg_wdata  input  8  write data. Unused upper bits are ignored.
- start  input  1  begin a scan frame. Level-sampled; honoured only in IDLE.
- stop  input  1  request graceful halt. Latched while busy.
- sw_en  output  NUM_CH  one-hot or zero switch enables.
- channel  output  3  index of the selected channel.
- sample_strobe  output  1  1-cycle pulse on the first DWELL cycle.
- frame_done  output  1  1-cycle pulse on the last DWELL cycle of a frame.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - Outputs: sw_en=0, channel=0, sample_strobe=0, frame_done=0, busy=0, state=IDLE.
  - Registers: MASK=0, SETTLE=0, DWELL=1, CTRL=0, stop_pending=0.
  - Reset mid-scan opens all switches at the first edge where rst is high.
- States: IDLE -> BREAK -> SETTLE -> DWELL -> (BREAK | IDLE).
- IDLE: sw_en=0.
  - start=1 and MASK!=0: channel is set to the lowest set MASK bit; go to BREAK.
  - start with MASK==0 is ignored.
- BREAK: sw_en=0 for exactly BBM_CYCLES cycles.
- SETTLE: sw_en=onehot(channel) for SETTLE cycles. SETTLE=0 skips the state.
- DWELL:
  - sw_en=onehot(channel) for max(DWELL,1) cycles.
  - sample_strobe is high on the first cycle only.
  - On the last cycle, the next channel is the next set MASK bit strictly above channel.
- Frame end: if no set MASK bit lies above channel (or MASK is now 0), that DWELL ends the frame and frame_done pulses on its last cycle. Then:
  - CONT=1, MASK!=0, no stop_pending: wrap to the lowest set bit and go to BREAK.
  - Otherwise: go to IDLE.
- stop:
  - stop_pending sets while busy.
  - At the end of the current DWELL, go to IDLE with frame_done=0 (unless that DWELL also ended the frame).
  - stop_pending clears on entering IDLE. stop in IDLE has no effect.
- Config writes:
  - Take effect on the next edge.
  - SETTLE/DWELL are loaded into the counters on entry to their states, so a write mid-state affects the next visit only.
  - MASK is read only at channel selection points.
- start while busy is ignored.
- Invariant: at most one sw_en bit is high. Any change of the closed channel passes through at least BBM_CYCLES all-zero cycles.
- Timing convention: cycle n is the interval after edge n. start sampled at edge 0 means cycle 1 is BREAK.

Test Plan:
- MASK=0b000101, SETTLE=2, DWELL=3, CONT=0, start pulse at edge 0 ->
  - cycles 1-2: sw_en=0.
  - cycles 3-7: sw_en=000001; strobe at cycle 5; channel=0.
  - cycles 8-9: sw_en=0.
  - cycles 10-14: sw_en=000100; strobe at 12; frame_done at 14.
  - cycle 15: busy=0.
- MASK=0b100000, SETTLE=0, DWELL=0, CONT=1 -> repeating 3-cycle pattern:
  - 2 cycles of sw_en=0;
  - then 1 cycle of sw_en=100000 with strobe=1 and frame_done=1 in the same cycle.
- CONT=1, MASK=0b000011, stop asserted during the ch0 SETTLE -> ch0 DWELL completes, then IDLE with sw_en=0 and no frame_done; ch1 is never enabled.
- start with MASK=0 -> busy stays 0 and sw_en stays 0. Writing MASK=0 during the ch1 DWELL of a CONT scan -> frame_done on the last cycle, then IDLE.
- rst asserted in a DWELL cycle -> next cycle sw_en=0, busy=0, and all registers at reset values. Deasserting rst and then pulsing start with MASK=0 does nothing.
- Random config writes/start/stop for 10k cycles -> a checker confirms:
  - sw_en is zero or one-hot;
  - at least BBM_CYCLES all-zero cycles between different channels;
  - strobe count equals DWELL entries.
